// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit:
// widths, R-type function codes and FSM encodings.
package mult_div_unit_pkg;

    localparam int NB_DATA  = 32;
    localparam int NB_FUNCT = 6;

    localparam logic [NB_FUNCT-1:0] FN_MULT  = 6'b011000;
    localparam logic [NB_FUNCT-1:0] FN_MULTU = 6'b011001;
    localparam logic [NB_FUNCT-1:0] FN_DIV   = 6'b011010;
    localparam logic [NB_FUNCT-1:0] FN_DIVU  = 6'b011011;
    localparam logic [NB_FUNCT-1:0] FN_MTHI  = 6'b010001;
    localparam logic [NB_FUNCT-1:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the
// multiply/divide unit (master = pipeline, slave = unit).
interface mult_div_unit_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
);
    logic                i_start;
    logic [NB_FUNCT-1:0] i_alu_ctrl;
    logic [NB_DATA-1:0]  i_rs;
    logic [NB_DATA-1:0]  i_rt;
    logic                o_busy;
    logic                o_done;
    logic [NB_DATA-1:0]  o_hi;
    logic [NB_DATA-1:0]  o_lo;

    modport master (
        output i_start, i_alu_ctrl, i_rs, i_rt,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_alu_ctrl, i_rs, i_rt,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/mult_div_unit_div_restoring_step.sv
// One restoring-division iteration: trial subtract of the
// divisor from the shifted partial remainder.
module div_restoring_step #(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA:0]   i_rem,
    input  logic [NB_DATA-1:0] i_divisor,
    output logic [NB_DATA-1:0] o_rem,
    output logic               o_q
);
    logic [NB_DATA:0] w_diff;

    assign w_diff = i_rem - {1'b0, i_divisor};
    assign o_q    = (i_rem >= {1'b0, i_divisor});
    assign o_rem  = o_q ? w_diff[NB_DATA-1:0] : i_rem[NB_DATA-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit owning HI/LO; 32 iterations
// over magnitudes, then one sign-fixup cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mult_div_unit_if.slave bus
);
    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    state_t r_state, w_next;

    logic [2*NB_DATA-1:0] r_acc;
    logic [NB_DATA-1:0]   r_b;
    logic [NB_CNT-1:0]    r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic                 r_done;
    logic [NB_DATA-1:0]   r_hi;
    logic [NB_DATA-1:0]   r_lo;

    logic [NB_FUNCT-1:0] w_ctrl;
    logic                w_idle_start;
    logic                w_is_mul, w_is_div, w_signed;
    logic                w_rs_neg, w_rt_neg;
    logic [NB_DATA-1:0]  w_rs_mag, w_rt_mag;

    assign w_ctrl       = bus.i_alu_ctrl;
    assign w_idle_start = bus.i_start && (r_state == ST_IDLE);
    assign w_is_mul     = (w_ctrl == FN_MULT) || (w_ctrl == FN_MULTU);
    assign w_is_div     = (w_ctrl == FN_DIV) || (w_ctrl == FN_DIVU);
    assign w_signed     = (w_ctrl == FN_MULT) || (w_ctrl == FN_DIV);
    assign w_rs_neg     = w_signed && bus.i_rs[NB_DATA-1];
    assign w_rt_neg     = w_signed && bus.i_rt[NB_DATA-1];
    assign w_rs_mag     = w_rs_neg ? -bus.i_rs : bus.i_rs;
    assign w_rt_mag     = w_rt_neg ? -bus.i_rt : bus.i_rt;

    // Multiply: acc = {partial product, remaining multiplier}
    logic [NB_DATA:0]     w_mul_sum;
    logic [2*NB_DATA-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]}
                      + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[NB_DATA-1:1]};

    // Divide: acc = {remainder, dividend bits -> quotient bits}
    logic [NB_DATA-1:0]   w_step_rem;
    logic                 w_step_q;
    logic [2*NB_DATA-1:0] w_div_next;

    div_restoring_step #(.NB_DATA(NB_DATA)) u_div_step (
        .i_rem     ({r_acc[2*NB_DATA-1:NB_DATA], r_acc[NB_DATA-1]}),
        .i_divisor (r_b),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    assign w_div_next = {w_step_rem, r_acc[NB_DATA-2:0], w_step_q};

    logic [2*NB_DATA-1:0] w_prod;
    logic [NB_DATA-1:0]   w_quot, w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_dz ? '1
                  : (r_neg_q ? -r_acc[NB_DATA-1:0] : r_acc[NB_DATA-1:0]);
    assign w_rem  = r_neg_r ? -r_acc[2*NB_DATA-1:NB_DATA]
                            : r_acc[2*NB_DATA-1:NB_DATA];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_idle_start && (w_is_mul || w_is_div)) w_next = ST_CALC;
            ST_CALC: if (r_cnt == CNT_LAST) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy = (r_state != ST_IDLE);
        bus.o_done = r_done;
        bus.o_hi   = r_hi;
        bus.o_lo   = r_lo;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == ST_FIX);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_idle_start && (w_is_mul || w_is_div)) begin
                        r_acc    <= {{NB_DATA{1'b0}}, w_is_mul ? w_rt_mag : w_rs_mag};
                        r_b      <= w_is_mul ? w_rs_mag : w_rt_mag;
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_dz     <= w_is_div && (bus.i_rt == '0);
                    end else if (w_idle_start && (w_ctrl == FN_MTHI)) begin
                        r_hi <= bus.i_rs;
                    end else if (w_idle_start && (w_ctrl == FN_MTLO)) begin
                        r_lo <= bus.i_rs;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*NB_DATA-1:NB_DATA];
                        r_lo <= w_prod[NB_DATA-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
